// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder/subtractor with start/busy/done handshake
//
// Purpose: time-multiplexes one 1-bit full-adder stage across WIDTH-bit
// operands, LSB first, one bit per clock.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE
//   sub    in   0 = a+b+c_in, 1 = a+~b+1 (c_in ignored)
//   a, b   in   WIDTH-bit operands, sampled with start
//   c_in   in   carry-in for add, sampled with start
//   busy   out  high while the serial computation runs
//   done   out  one-cycle pulse, result valid
//   sum    out  registered result, held until the next completion
//   c_out  out  carry out of bit WIDTH-1 (subtract: 1 = no borrow)

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             co_bit;
  logic             last_step;

  // The single shared full-adder stage.
  assign {co_bit, s_bit} = {1'b0, a_sh[0]} + {1'b0, b_sh[0]} + {1'b0, carry};
  assign res_nxt   = {s_bit, res_sh[WIDTH-1:1]};
  assign last_step = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state only.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      c_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            // Subtraction as a + ~b + 1: invert b and force carry-in to one.
            b_sh   <= sub ? ~b : b;
            carry  <= sub ? 1'b1 : c_in;
            cnt    <= '0;
            res_sh <= '0;
          end
        end
        RUN: begin
          res_sh <= res_nxt;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= co_bit;
          cnt    <= cnt + 1'b1;
          if (last_step) begin
            sum   <= res_nxt;
            c_out <= co_bit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sub = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             c_in = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .c_in(c_in), .busy(busy), .done(done), .sum(sum), .c_out(c_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {carry_out, result} of the full-width operation.
  function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                            input logic ci, input logic s);
    logic [WIDTH-1:0] ny;
    longint unsigned  t;
    ny = ~y;
    if (s) t = longint'(x) + longint'(ny) + 1;
    else   t = longint'(x) + longint'(y) + longint'(ci);
    return t[WIDTH:0];
  endfunction

  // Transaction-level model: an accepted request is "age" edges old; the
  // result appears WIDTH edges after acceptance and the block is free again
  // WIDTH+2 edges after acceptance.
  bit               m_active = 0;
  int               m_age = 0;
  logic [WIDTH:0]   m_pending = '0;
  logic [WIDTH-1:0] m_sum = '0;
  logic             m_cout = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0;
      m_age    = 0;
      m_sum    = '0;
      m_cout   = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active  = 1;
        m_age     = 0;
        m_pending = ref_op(a, b, c_in, sub);
      end
    end else begin
      m_age++;
      if (m_age == WIDTH) begin
        m_sum  = m_pending[WIDTH-1:0];
        m_cout = m_pending[WIDTH];
      end
      if (m_age == WIDTH + 1) m_active = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", busy, (m_active && m_age < WIDTH) ? 1 : 0);
      check("done", done, (m_active && m_age == WIDTH) ? 1 : 0);
      check("sum", sum, m_sum);
      check("c_out", c_out, m_cout);
    end
  end

  task automatic wait_idle();
    start = 1'b0;
    repeat (WIDTH + 4) @(posedge clk);
  endtask

  // Issues one request, checks latency, busy length and the literal result.
  task automatic do_op(input string nm, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                       input logic ci, input logic s, input bit perturb,
                       input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    int n;
    int nbusy;
    @(posedge clk); #2;
    a = xa; b = xb; c_in = ci; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    nbusy = 0;
    while (n < 20) begin
      @(negedge clk);
      if (done) break;
      if (busy) nbusy++;
      if (perturb && n == 3) begin
        a = ~xa; b = xa ^ xb; c_in = ~ci; sub = ~s; start = 1'b1;
      end
      if (perturb && n == 4) start = 1'b0;
      n++;
    end
    check({nm, "_latency"}, n, WIDTH);
    check({nm, "_busy_cycles"}, nbusy, WIDTH);
    check({nm, "_sum"}, sum, exp_sum);
    check({nm, "_c_out"}, c_out, exp_cout);
  endtask

  initial begin
    int ndone;
    logic [WIDTH:0] r;

    // Pin the reference arithmetic with hand-computed values.
    r = ref_op(8'hFF, 8'h01, 1'b0, 1'b0); check("ref_ff_01", r, 9'h100);
    r = ref_op(8'h5A, 8'h33, 1'b1, 1'b0); check("ref_5a_33", r, 9'h08E);
    r = ref_op(8'h10, 8'h01, 1'b1, 1'b1); check("ref_sub_10_01", r, 9'h10F);
    r = ref_op(8'h01, 8'h02, 1'b0, 1'b1); check("ref_sub_01_02", r, 9'h0FF);

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_c_out", c_out, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 0, 8'h00, 1'b1);
    wait_idle();
    do_op("add_5a_33", 8'h5A, 8'h33, 1'b1, 1'b0, 0, 8'h8E, 1'b0);
    wait_idle();
    do_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 0, 8'h0F, 1'b1);
    wait_idle();
    do_op("sub_01_02", 8'h01, 8'h02, 1'b0, 1'b1, 0, 8'hFF, 1'b0);
    wait_idle();
    do_op("sub_10_01_cin", 8'h10, 8'h01, 1'b1, 1'b1, 0, 8'h0F, 1'b1);
    wait_idle();
    do_op("sub_01_02_cin", 8'h01, 8'h02, 1'b1, 1'b1, 0, 8'hFF, 1'b0);
    wait_idle();
    do_op("perturb", 8'h5A, 8'h33, 1'b1, 1'b0, 1, 8'h8E, 1'b0);
    wait_idle();

    // Asynchronous reset in the middle of RUN.
    @(posedge clk); #2;
    a = 8'hC3; b = 8'h3C; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sum", sum, 0);
    check("arst_c_out", c_out, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    do_op("after_rst", 8'h80, 8'h80, 1'b1, 1'b0, 0, 8'h01, 1'b1);
    wait_idle();

    // start held high: one result per WIDTH+2 cycles.
    @(posedge clk); #2;
    a = 8'h21; b = 8'h43; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("held_start_dones", ndone, 3);
    check("held_start_sum", sum, 8'h64);
    wait_idle();

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 3) == 0);
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      c_in  = 1'($urandom);
      sub   = 1'($urandom);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder/subtractor controller. It time-multiplexes a single 1-bit full-adder stage (sum/carry of a, b, c_in) across WIDTH-bit operands, one bit per clock, LSB first. A start/busy/done handshake sequences the operation. The block is the area-minimal alternative to a WIDTH-bit ripple adder in the logic-modules library.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
sub  input  1  0 = add (a+b+c_in); 1 = subtract (a+~b+1, c_in ignored); sampled with start.
a  input  WIDTH  operand A; sampled with start.
b  input  WIDTH  operand B; sampled with start.
c_in  input  1  carry-in for add; sampled with start.
busy  output  1  high while serial computation in progress.
done  output  1  single-cycle pulse; result valid.
sum  output  WIDTH  registered result; held until next completion.
c_out  output  1  final carry; in subtract mode 1 = no borrow (a >= b unsigned).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, sum=0, c_out=0, internal shift regs/carry/counter=0. Effective immediately; aborts any operation in progress, and no done is produced for the aborted op.
- FSM states: IDLE, RUN, DONE.
- IDLE: on clk edge with start=1:
  - load a_sh=a, b_sh = sub ? ~b : b, carry = sub ? 1 : c_in, cnt=0, res_sh=0.
  - go to RUN.
  - start=0 stays in IDLE.
- RUN, each edge:
  - {co,s} = a_sh[0] + b_sh[0] + carry.
  - res_sh = {s, res_sh[WIDTH-1:1]}; a_sh, b_sh shift right by 1; carry=co; cnt=cnt+1.
  - On the edge where cnt==WIDTH-1 (the WIDTH-th RUN edge): sum <= final shifted result, c_out <= co, go to DONE.
- DONE: done=1 for exactly this one cycle; next edge go to IDLE unconditionally. start in DONE is ignored.
- busy=1 exactly in RUN; done=1 exactly in DONE; both are Moore outputs decoded from registered state.
- Latency: start sampled at edge 0; RUN occupies edges 1..WIDTH; done high for the cycle after edge WIDTH.
- Throughput: start held high continuously yields one result per WIDTH+2 cycles.
- Operand isolation:
  - start, a, b, c_in, sub are ignored outside IDLE.
  - Input changes during RUN do not affect the result.
- sum/c_out change only on the final RUN edge (or on reset); they are stable in DONE and IDLE.
- Arithmetic: unsigned modulo 2^WIDTH. c_out is the carry out of bit WIDTH-1. No overflow flag.
- cnt width = clog2(WIDTH); wraps are never reached because the FSM leaves RUN at WIDTH-1.
- The 1-bit stage is combinational and internal; no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, add, a=8'hFF, b=8'h01, c_in=0 -> done exactly 9 cycles after start edge; sum=8'h00, c_out=1; busy high for 8 cycles.
- Add, a=8'h5A, b=8'h33, c_in=1 -> sum=8'h8E, c_out=0.
- Subtract, a=8'h10, b=8'h01 -> sum=8'h0F, c_out=1. Then a=8'h01, b=8'h02 -> sum=8'hFF, c_out=0. c_in=1 must not change either result.
- start pulsed and a/b changed during RUN (e.g. at cycle 3) -> ignored; result equals the originally sampled operands; only one done pulse.
- rst_n low at cycle 4 of RUN -> busy/done/sum/c_out go 0 asynchronously; no done follows. A new start after release computes correctly.
- start held high with constant operands for 30 cycles -> done pulses at cycles 9, 19, 29 (period 10). sum is stable between pulses.
